// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with tick-based debounce, one-shot key
// code output and a four-digit history shift register (bcd0 newest).
module keypad_scan #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int SCAN_FREQ      = 1000,
    parameter int DEBOUNCE_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic       clr,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3
);

    localparam int DIV = CLK_FREQ / SCAN_FREQ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    row_m, row_s;
    logic [3:0]    row_low;
    logic          one_low;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]    col_nxt, col_rot;
    logic [3:0]    lat_row, lat_row_nxt;
    logic          fire;

    function automatic logic [1:0] zero_pos(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            default:  return 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    assign row_low = ~row_s;
    assign one_low = (row_low != 4'h0) && ((row_low & (row_low - 4'd1)) == 4'h0);
    assign col_rot = {col[2:0], col[3]};
    assign cnt_inc = cnt + CW'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every transition and counter update is gated by tick
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        col_nxt     = col;
        lat_row_nxt = lat_row;
        fire        = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        lat_row_nxt = row_s;
                        cnt_nxt     = CW'(1);
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_nxt = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (row_s == lat_row) begin
                        if (cnt_inc == DEB_MAX) begin
                            fire      = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = HELD;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        col_nxt   = col_rot;
                        state_nxt = SCAN;
                    end
                end
                HELD: begin
                    if (row_s == 4'hF) begin
                        if (cnt_inc == DEB_MAX) begin
                            cnt_nxt   = '0;
                            col_nxt   = col_rot;
                            state_nxt = SCAN;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    col_nxt   = 4'b1110;
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        key_down = (state == HELD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col       <= 4'b1110;
            cnt       <= '0;
            lat_row   <= '1;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            col       <= col_nxt;
            cnt       <= cnt_nxt;
            lat_row   <= lat_row_nxt;
            key_valid <= fire;
            if (fire) begin
                key_code <= key_map(zero_pos(lat_row), zero_pos(col));
            end
        end
    end

    // Digits shift one clk after the debounce tick, in the key_valid cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd0 <= '0;
            bcd1 <= '0;
            bcd2 <= '0;
            bcd3 <= '0;
        end else if (clr) begin
            bcd0 <= key_valid ? key_code : 4'h0;
            bcd1 <= '0;
            bcd2 <= '0;
            bcd3 <= '0;
        end else if (key_valid) begin
            bcd0 <= key_code;
            bcd1 <= bcd0;
            bcd2 <= bcd1;
            bcd3 <= bcd2;
        end
    end

endmodule
